// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/loader access to a word-wide synchronous RAM with sub-word read extraction and read-modify-write
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN
module dmem_arbiter #(
    parameter int RAM_AW    = 14,
    parameter bit LAST_INIT = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic [31:0]       ldr_rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, MERGE_WR, DONE} state_t;
    state_t            r_state, w_next;
    logic              r_last, r_id, r_we, r_uns, r_cpu_ack, r_ldr_ack, r_err;
    logic [1:0]        r_size;
    logic [RAM_AW+1:0] r_addr;
    logic [31:0]       r_wdata, r_merged, r_cpu_rdata, r_ldr_rdata;
    logic              w_tie, w_grant, w_pick_ldr, w_g_we, w_misalign, w_word_wr, w_nid, w_unused;
    logic [1:0]        w_g_size;
    logic [31:0]       w_g_addr, w_g_wdata, w_ext, w_merge;
    logic [4:0]        w_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    assign w_tie      = cpu_req & ldr_req;
    assign w_grant    = cpu_req | ldr_req;
    assign w_pick_ldr = ldr_req & (~cpu_req | ~r_last);
    assign w_g_we     = w_pick_ldr ? ldr_we : cpu_we;
    assign w_g_size   = w_pick_ldr ? 2'b10 : cpu_size;
    assign w_g_addr   = w_pick_ldr ? ldr_addr : cpu_addr;
    assign w_g_wdata  = w_pick_ldr ? ldr_wdata : cpu_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = w_g_size[1] ? |w_g_addr[1:0] : (w_g_size[0] & w_g_addr[0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_word_wr  = r_we & r_size[1];
    assign w_nid      = (r_state == IDLE) ? w_pick_ldr : r_id;
    assign w_sh       = {r_addr[1:0], 3'b000};
    assign w_byte     = 8'(ram_rdata >> w_sh);
    assign w_half     = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign w_ext      = r_size[1] ? ram_rdata
                      : r_size[0] ? {{16{~r_uns & w_half[15]}}, w_half}
                      : {{24{~r_uns & w_byte[7]}}, w_byte};
    assign w_merge    = r_size[0] ? (r_addr[1] ? {r_wdata[15:0], ram_rdata[15:0]} : {ram_rdata[31:16], r_wdata[15:0]})
                      : (ram_rdata & ~(32'hFF << w_sh)) | ({24'd0, r_wdata[7:0]} << w_sh);
    assign w_unused   = ^{cpu_addr[31:RAM_AW+2], ldr_addr[31:RAM_AW+2]};
    // A merge write pending when reset arrives must not reach the RAM
    assign ram_we     = ~reset & ((r_state == ACCESS & w_word_wr) | r_state == MERGE_WR);
    assign ram_addr   = r_addr[RAM_AW+1:2];
    assign ram_wdata  = (r_state == MERGE_WR) ? r_merged : r_wdata;
    assign busy       = r_state != IDLE;
    assign cpu_ack    = r_cpu_ack;
    assign ldr_ack    = r_ldr_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign ldr_rdata  = r_ldr_rdata;
    assign err        = r_err;
    // Next-state logic for the access sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_grant ? (w_misalign ? DONE : ACCESS) : IDLE;
            ACCESS:   w_next = w_word_wr ? DONE : WAIT;
            WAIT:     w_next = r_we ? MERGE_WR : DONE;
            MERGE_WR: w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end
    // State, grant latch, read capture/merge and one-cycle ack generation
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= LAST_INIT;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_merged    <= '0;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cpu_ack <= (w_next == DONE) & ~w_nid;
            r_ldr_ack <= (w_next == DONE) & w_nid;
            r_err     <= (w_next == DONE) & (r_state == IDLE);
            if (r_state == IDLE && w_grant) begin
                r_id    <= w_pick_ldr;
                r_we    <= w_g_we;
                r_size  <= w_g_size;
                r_uns   <= ~w_pick_ldr & cpu_unsigned;
                r_addr  <= w_g_addr[RAM_AW+1:0];
                r_wdata <= w_g_wdata;
                if (w_tie)
                    r_last <= w_pick_ldr;
                if (w_misalign && w_pick_ldr)
                    r_ldr_rdata <= '0;
                if (w_misalign && !w_pick_ldr)
                    r_cpu_rdata <= '0;
            end
            if (r_state == WAIT) begin
                r_merged <= w_merge;
                if (!r_we && r_id)
                    r_ldr_rdata <= w_ext;
                if (!r_we && !r_id)
                    r_cpu_rdata <= w_ext;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven CPU vectors plus hand sequences for contention, loader burst and reset abort
module tb_dmem_arbiter;
    logic        clock = 1'b0, reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [1:0]  cpu_size = 2'b10;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
    logic        cpu_ack, ldr_ack, ram_we, busy, err;
    logic [31:0] cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
    logic [13:0] ram_addr;
    logic [31:0] mem [0:16383];
    int          errors = 0, checks = 0, cyc = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, d, exp_rd;
        int          exp_lat, exp_wc;
        logic [31:0] exp_wd;
    } vec_t;
    vec_t tv [16];

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Word RAM model with one-cycle synchronous read
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // One transaction from cycle 0 (grant) to ack; requester then releases req and idles a cycle
    task automatic op(input logic sel, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e,
                      output int wn, output int wc, output logic [31:0] wd, output int oth, output int ac);
        if (sel) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns; cpu_addr = a; cpu_wdata = d;
        end
        lat = 0; wn = 0; wc = 0; wd = '0; oth = 0;
        while (!(sel ? ldr_ack : cpu_ack) && lat < 20) begin
            tick;
            lat++;
            if (ram_we) begin wn++; wc = lat; wd = ram_wdata; end
            if (sel ? cpu_ack : ldr_ack) oth++;
        end
        ac = cyc;
        rd = sel ? ldr_rdata : cpu_rdata;
        e = err;
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        int lat, wn, wc, oth, ac, ca, la;
        int acs [3];
        logic [31:0] rd, wd;
        logic e;
        for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
        mem[16] <= 32'h11223344;
        tv[0]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h11223344, 3, 0, 32'h0};
        tv[1]  = '{1'b1, 2'd0, 1'b0, 32'h41, 32'hAB,       32'h0,        4, 3, 32'h1122AB44};
        tv[2]  = '{1'b0, 2'd0, 1'b0, 32'h41, 32'h0,        32'hFFFFFFAB, 3, 0, 32'h0};
        tv[3]  = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        32'h00001122, 3, 0, 32'h0};
        tv[4]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h1122AB44, 3, 0, 32'h0};
        tv[5]  = '{1'b1, 2'd1, 1'b0, 32'h46, 32'hBEEF,     32'h0,        4, 3, 32'hBEEF0000};
        tv[6]  = '{1'b0, 2'd1, 1'b0, 32'h46, 32'h0,        32'hFFFFBEEF, 3, 0, 32'h0};
        tv[7]  = '{1'b0, 2'd0, 1'b1, 32'h47, 32'h0,        32'h000000BE, 3, 0, 32'h0};
        tv[8]  = '{1'b1, 2'd2, 1'b0, 32'h48, 32'h80000001, 32'h0,        2, 1, 32'h80000001};
        tv[9]  = '{1'b0, 2'd0, 1'b0, 32'h48, 32'h0,        32'h00000001, 3, 0, 32'h0};
        tv[10] = '{1'b0, 2'd0, 1'b0, 32'h4B, 32'h0,        32'hFFFFFF80, 3, 0, 32'h0};
        tv[11] = '{1'b0, 2'd1, 1'b0, 32'h4A, 32'h0,        32'hFFFF8000, 3, 0, 32'h0};
        tv[12] = '{1'b0, 2'd3, 1'b0, 32'h48, 32'h0,        32'h80000001, 3, 0, 32'h0};
        tv[13] = '{1'b1, 2'd0, 1'b0, 32'h43, 32'hFFFFFF55, 32'h0,        4, 3, 32'h5522AB44};
        tv[14] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h5522AB44, 3, 0, 32'h0};
        tv[15] = '{1'b0, 2'd0, 1'b1, 32'h42, 32'h0,        32'h00000022, 3, 0, 32'h0};

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst ldr_ack", {31'd0, ldr_ack}, 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        chk("rst ldr_rdata", ldr_rdata, 32'd0);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst ram_wdata", ram_wdata, 32'd0);
        chk("rst ram_addr", {18'd0, ram_addr}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);

        for (int r = 0; r < 3; r++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h80; cpu_wdata = 32'hC0 + r;
            ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h84; ldr_wdata = 32'hD0 + r;
            ca = -1; la = -1;
            for (int k = 1; k <= 10; k++) begin
                tick;
                if (cpu_ack) begin ca = k; cpu_req = 1'b0; end
                if (ldr_ack) begin la = k; ldr_req = 1'b0; end
            end
            chk($sformatf("tie%0d cpu ack cycle", r), ca, (r == 1) ? 5 : 2);
            chk($sformatf("tie%0d ldr ack cycle", r), la, (r == 1) ? 2 : 5);
            chk($sformatf("tie%0d cpu word", r), mem[32], 32'hC0 + r);
            chk($sformatf("tie%0d ldr word", r), mem[33], 32'hD0 + r);
        end

        for (int i = 0; i < 16; i++) begin
            op(1'b0, tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].d, lat, rd, e, wn, wc, wd, oth, ac);
            chk($sformatf("v%0d latency", i), lat, tv[i].exp_lat);
            if (!tv[i].we) chk($sformatf("v%0d rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("v%0d ram_we count", i), wn, (tv[i].exp_wc != 0) ? 1 : 0);
            if (tv[i].exp_wc != 0) begin
                chk($sformatf("v%0d ram_we cycle", i), wc, tv[i].exp_wc);
                chk($sformatf("v%0d ram_wdata", i), wd, tv[i].exp_wd);
            end
            chk($sformatf("v%0d err", i), {31'd0, e}, 32'd0);
            chk($sformatf("v%0d ldr_ack stray", i), oth, 0);
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h42, 32'hDEADBEEF, lat, rd, e, wn, wc, wd, oth, ac);
        chk("trap latency", lat, 1);
        chk("trap err", {31'd0, e}, 32'd1);
        chk("trap rdata", rd, 32'd0);
        chk("trap ram_we count", wn, 0);
        chk("trap word intact", mem[16], 32'h5522AB44);
`else
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, e, wn, wc, wd, oth, ac);
        chk("unaligned word rdata", rd, 32'h5522AB44);
        chk("unaligned word err", {31'd0, e}, 32'd0);
        op(1'b0, 1'b0, 2'b01, 1'b1, 32'h43, 32'h0, lat, rd, e, wn, wc, wd, oth, ac);
        chk("unaligned half rdata", rd, 32'h00005522);
`endif

        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'(i + 1), lat, rd, e, wn, wc, wd, oth, ac);
            acs[i] = ac;
            chk($sformatf("burst%0d latency", i), lat, 2);
            chk($sformatf("burst%0d cpu_ack stray", i), oth, 0);
        end
        chk("burst spacing 1", acs[1] - acs[0], 4);
        chk("burst spacing 2", acs[2] - acs[1], 4);
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, lat, rd, e, wn, wc, wd, oth, ac);
            chk($sformatf("burst%0d readback", i), rd, 32'(i + 1));
            chk($sformatf("burst%0d read latency", i), lat, 3);
        end

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_addr = 32'h40; cpu_wdata = 32'h7777;
        wn = 0; oth = 0;
        for (int k = 1; k <= 2; k++) begin
            tick;
            if (ram_we) wn++;
            if (cpu_ack) oth++;
        end
        tick;
        reset = 1'b1;
        #1;
        chk("abort busy in merge", {31'd0, busy}, 32'd1);
        chk("abort ram_we in reset", {31'd0, ram_we}, 32'd0);
        chk("abort early ram_we", wn, 0);
        cpu_req = 1'b0;
        if (cpu_ack) oth++;
        tick;
        if (cpu_ack) oth++;
        chk("abort busy after", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick;
        if (cpu_ack) oth++;
        chk("abort no ack", oth, 0);
        chk("abort word intact", mem[16], 32'h5522AB44);
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, e, wn, wc, wd, oth, ac);
        chk("abort readback", rd, 32'h5522AB44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
